// File: rtl/music_sequencer_pkg.sv
// music_sequencer_pkg: shared note codes and sequencer state encoding
package music_sequencer_pkg;
    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;
    localparam int NOTE_REST = 0;
    localparam int NOTE_HOLD = 1;
endpackage

// File: rtl/music_sequencer_if.sv
// music_sequencer_if: control, ROM and voice output bundle of the sequencer
interface music_sequencer_if #(
    parameter int VOICES = 2,
    parameter int NOTE_W = 7,
    parameter int ADDR_W = 10
);
    logic                       sample_en;
    logic                       play;
    logic                       stop;
    logic                       pause;
    logic                       loop_en;
    logic [ADDR_W-1:0]          rom_addr;
    logic [VOICES*NOTE_W-1:0]   rom_data;
    logic [VOICES*NOTE_W-1:0]   note;
    logic [VOICES-1:0]          rest;
    logic                       busy;
    logic                       done;
    modport master (output sample_en, play, stop, pause, loop_en, rom_data,
                    input rom_addr, note, rest, busy, done);
    modport slave (input sample_en, play, stop, pause, loop_en, rom_data,
                   output rom_addr, note, rest, busy, done);
endinterface

// File: rtl/music_sequencer_step_timer.sv
// step_timer: per-step sample counter emitting articulate/load/end strobes
module step_timer #(
    parameter int BEAT = 5538,
    parameter int GAP  = 960
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic sample_en,
    input  logic run,
    input  logic clr,
    output logic artic,
    output logic load,
    output logic step_end
);
    localparam int CW = $clog2(BEAT);
    logic [CW-1:0] cnt;
    logic          tick;
    assign tick     = run && sample_en;
    assign artic    = tick && cnt == '0;
    assign load     = tick && cnt == CW'(GAP);
    assign step_end = tick && cnt == CW'(BEAT - 1);
    always_ff @(posedge sys_clk)
        if (sys_rst || clr) cnt <= '0;
        else if (tick) cnt <= step_end ? '0 : cnt + 1'b1;
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: N-voice ROM score player with play/stop/pause, loop and articulation gap
module music_sequencer
    import music_sequencer_pkg::*;
#(
    parameter int VOICES  = 2,
    parameter int NOTE_W  = 7,
    parameter int ADDR_W  = 10,
    parameter int ROM_LEN = 432,
    parameter int BEAT    = 5538,
    parameter int GAP     = 960
) (
    input logic sys_clk,
    input logic sys_rst,
    music_sequencer_if.slave bus
);
    if (BEAT < 4 || GAP < 1 || GAP > BEAT - 2) begin : g_bad_timing
        $error("music_sequencer: need BEAT >= 4 and 1 <= GAP <= BEAT-2");
    end
    state_t state, state_nxt;
    logic   artic, load, step_end, run, last_addr, idle_nxt, clear, done_nxt;
    assign run       = state != IDLE && !bus.pause;
    assign last_addr = bus.rom_addr == ADDR_W'(ROM_LEN - 1);
    assign clear     = sys_rst || idle_nxt;
    step_timer #(.BEAT(BEAT), .GAP(GAP)) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .sample_en (bus.sample_en),
        .run       (run),
        .clr       (state == IDLE || bus.stop),
        .artic     (artic),
        .load      (load),
        .step_end  (step_end)
    );
    always_ff @(posedge sys_clk)
        state <= sys_rst ? IDLE : state_nxt;
    always_comb
        state_nxt = bus.stop                                            ? IDLE :
                    (state == IDLE && bus.play)                         ? RUN  :
                    (state == RUN && load && last_addr && !bus.loop_en) ? LAST :
                    (state == LAST && step_end)                         ? IDLE : state;
    always_comb begin
        idle_nxt = state_nxt == IDLE;
        done_nxt = state == LAST && step_end && !bus.stop;
    end
    always_ff @(posedge sys_clk) begin
        bus.busy <= !clear;
        bus.done <= !sys_rst && done_nxt;
    end
    always_ff @(posedge sys_clk)
        if (clear) bus.rom_addr <= '0;
        else if (load) bus.rom_addr <= (last_addr && bus.loop_en) ? '0 : bus.rom_addr + 1'b1;
    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        logic [NOTE_W-1:0] code, note_r;
        logic              hold, mute, mute_nxt, rest_r;
        assign code = bus.rom_data[v*NOTE_W +: NOTE_W];
        assign hold = code == NOTE_W'(NOTE_HOLD);
        assign bus.note[v*NOTE_W +: NOTE_W] = note_r;
        assign bus.rest[v] = rest_r;
        // articulation mutes every re-struck voice; the load then unmutes unless it is a rest
        always_comb
            mute_nxt = (artic && !hold) ? 1'b1 :
                       (load && !hold)  ? code == NOTE_W'(NOTE_REST) : mute;
        always_ff @(posedge sys_clk) begin
            note_r <= clear ? '0 : (load && !hold) ? code : note_r;
            mute   <= clear || mute_nxt;
            rest_r <= clear || mute_nxt || bus.pause;
        end
    end
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed checks of one-shot, loop, pause, stop and reset behaviour
module tb_music_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   total = 0, passes = 0, scnt = 0, done_cnt = 0, done_at = -1;
    logic done_busy;
    logic [13:0] rom [4];
    always #5 clk = ~clk;
    music_sequencer_if #(.VOICES(2), .NOTE_W(7), .ADDR_W(10)) bus ();
    music_sequencer #(
        .VOICES(2), .NOTE_W(7), .ADDR_W(10), .ROM_LEN(4), .BEAT(8), .GAP(2)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );
    always @(posedge clk)
        bus.rom_data <= bus.rom_addr < 10'd4 ? rom[bus.rom_addr[1:0]] : 14'd0;
    always @(negedge clk)
        if (bus.done) begin
            done_cnt++;
            done_at   = scnt;
            done_busy = bus.busy;
        end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic samples(input int n);
        for (int i = 0; i < n; i++) begin
            scnt++;
            bus.sample_en = 1'b1;
            @(negedge clk);
            bus.sample_en = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic start();
        scnt = 0;
        done_cnt = 0;
        done_at = -1;
        bus.play = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
    endtask

    initial begin
        rom[0] = {7'd40, 7'd30};
        rom[1] = {7'd0, 7'd1};
        rom[2] = {7'd1, 7'd31};
        rom[3] = {7'd0, 7'd0};
        rst = 1'b1;
        bus.sample_en = 1'b0; bus.play = 1'b0; bus.stop = 1'b0;
        bus.pause = 1'b0; bus.loop_en = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rest", bus.rest, 2'b11);
        check("reset_note", bus.note, 0);
        check("reset_addr", bus.rom_addr, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);

        // one-shot
        start();
        check("os_busy_rise", bus.busy, 1);
        samples(2);
        check("os_rest_pre", bus.rest, 2'b11);
        check("os_note_pre", bus.note, 0);
        samples(1);
        check("os_note_s0", bus.note, {7'd40, 7'd30});
        check("os_rest_s0", bus.rest, 2'b00);
        check("os_addr_s0", bus.rom_addr, 1);
        samples(6);
        check("os_artic_s1", bus.rest, 2'b10);
        samples(2);
        check("os_rest_s1", bus.rest, 2'b10);
        check("os_note_s1", bus.note, {7'd0, 7'd30});
        check("os_addr_s1", bus.rom_addr, 2);
        samples(6);
        check("os_artic_s2", bus.rest, 2'b11);
        check("os_note_art", bus.note, {7'd0, 7'd30});
        samples(1);
        check("os_artic_s2b", bus.rest, 2'b11);
        samples(1);
        check("os_rest_s2", bus.rest, 2'b10);
        check("os_note_s2", bus.note, {7'd0, 7'd31});
        check("os_addr_s2", bus.rom_addr, 3);
        samples(12);
        check("os_nodone31", done_cnt, 0);
        check("os_busy31", bus.busy, 1);
        samples(1);
        check("os_done_cnt", done_cnt, 1);
        check("os_done_at", done_at, 32);
        check("os_done_busy", done_busy, 0);
        check("os_end_busy", bus.busy, 0);
        check("os_end_rest", bus.rest, 2'b11);
        check("os_end_note", bus.note, 0);
        check("os_end_addr", bus.rom_addr, 0);

        // loop
        bus.loop_en = 1'b1;
        start();
        for (int k = 0; k < 5; k++) begin
            samples(k == 0 ? 3 : 8);
            check("loop_addr", bus.rom_addr, (k + 1) % 4);
        end
        samples(29);
        check("loop_nodone", done_cnt, 0);
        check("loop_busy", bus.busy, 1);
        bus.loop_en = 1'b0;
        samples(32);
        check("loop_end_cnt", done_cnt, 1);
        check("loop_end_at", done_at, 96);
        check("loop_end_busy", bus.busy, 0);

        // pause
        start();
        samples(12);
        bus.pause = 1'b1;
        @(negedge clk);
        check("pause_rest", bus.rest, 2'b11);
        samples(20);
        check("pause_addr", bus.rom_addr, 2);
        check("pause_note", bus.note, {7'd0, 7'd30});
        bus.pause = 1'b0;
        @(negedge clk);
        check("unpause_rest", bus.rest, 2'b10);
        samples(20);
        check("pause_done_cnt", done_cnt, 1);
        check("pause_done_at", done_at, 52);

        // stop mid-step and collision
        start();
        samples(17);
        bus.stop = 1'b1;
        @(negedge clk);
        bus.stop = 1'b0;
        check("stop_rest", bus.rest, 2'b11);
        check("stop_busy", bus.busy, 0);
        samples(20);
        check("stop_nodone", done_cnt, 0);
        check("stop_addr", bus.rom_addr, 0);
        bus.play = 1'b1;
        bus.stop = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
        bus.stop = 1'b0;
        check("collide_busy", bus.busy, 0);

        // play while busy, then reset on a load cycle
        start();
        samples(11);
        bus.play = 1'b1;
        @(negedge clk);
        bus.play = 1'b0;
        check("replay_addr", bus.rom_addr, 2);
        check("replay_busy", bus.busy, 1);
        samples(7);
        scnt++;
        bus.sample_en = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        bus.sample_en = 1'b0;
        rst = 1'b0;
        check("rst_rest", bus.rest, 2'b11);
        check("rst_note", bus.note, 0);
        check("rst_addr", bus.rom_addr, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_nodone", done_cnt, 0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
